// File: rtl/hack_memory_pkg.sv
// Shared constants, region encoding and address decode for the Hack data memory.
package hack_memory_pkg;

  localparam logic [15:0] SCREEN_BASE = 16'h4000;
  localparam logic [15:0] KBD_ADDR    = 16'h6000;

  localparam int unsigned SCR_OFFSET_W = 13;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned SCR_ENTRY_W  = SCR_OFFSET_W + DATA_W;

  typedef enum logic [1:0] {
    RegionRam,
    RegionScreen,
    RegionKbd,
    RegionNone
  } region_e;

  typedef struct packed {
    logic [SCR_OFFSET_W-1:0] addr;
    logic [DATA_W-1:0]       data;
  } scr_entry_t;

  // Map a CPU data address onto the region that answers it. RAM never extends into
  // the screen window, and the screen never extends into the keyboard address.
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input int unsigned ram_words,
                                            input int unsigned screen_words);
    region_e region;
    int unsigned addr_u;
    addr_u = 32'(addr);
    region = RegionNone;
    if (addr < SCREEN_BASE) begin
      if (addr_u < ram_words) region = RegionRam;
    end else if (addr < KBD_ADDR) begin
      if ((addr_u - 32'(SCREEN_BASE)) < screen_words) region = RegionScreen;
    end else if (addr == KBD_ADDR) begin
      region = RegionKbd;
    end
    return region;
  endfunction

endpackage

// File: rtl/hack_memory_screen_fifo.sv
// Synchronous FIFO carrying screen updates to the display agent. The head is
// registered storage, so a push into an empty FIFO shows up one cycle later.
module screen_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 29
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO only succeeds when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Pointer and occupancy next-state; Depth is a power of two so pointers wrap freely.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Pointer/count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; not reset, stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/hack_memory.sv
// Hack CPU data memory: RAM, screen memory and keyboard register behind one
// combinational read port, plus a stream of screen writes to a display agent.
module hack_memory
  import hack_memory_pkg::*;
#(
  parameter int unsigned RAM_WORDS    = 16384,
  parameter int unsigned SCREEN_WORDS = 8192,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             addressM,
  input  logic [15:0]             outM,
  input  logic                    writeM,
  output logic [15:0]             inM,
  input  logic                    kbd_valid,
  input  logic [15:0]             kbd_code,
  output logic                    scr_valid,
  input  logic                    scr_ready,
  output logic [SCR_OFFSET_W-1:0] scr_addr,
  output logic [15:0]             scr_data,
  output logic                    scr_overflow
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam int unsigned ScrAw = $clog2(SCREEN_WORDS);

  logic [15:0] ram_q [RAM_WORDS];
  logic [15:0] scr_mem_q [SCREEN_WORDS];
  logic [15:0] kbd_q, kbd_d;
  logic        ovf_q, ovf_d;

  region_e     region;
  logic [RamAw-1:0] ram_idx;
  logic [ScrAw-1:0] scr_idx;
  logic        ram_we, scr_we;
  logic        fifo_full, fifo_empty, fifo_pop;
  scr_entry_t  push_entry, head_entry;

  assign ram_idx = addressM[RamAw-1:0];
  assign scr_idx = addressM[ScrAw-1:0];

  // Decode the CPU address into the region that owns it.
  always_comb begin
    region = decode_region(addressM, RAM_WORDS, SCREEN_WORDS);
  end

  // Combinational read mux; unmapped addresses read as zero.
  always_comb begin
    inM = '0;
    unique case (region)
      RegionRam:    inM = ram_q[ram_idx];
      RegionScreen: inM = scr_mem_q[scr_idx];
      RegionKbd:    inM = kbd_q;
      default:      inM = '0;
    endcase
  end

  // Writes are ignored while reset is asserted.
  assign ram_we = reset && writeM && (region == RegionRam);
  assign scr_we = reset && writeM && (region == RegionScreen);

  // RAM array; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= outM;
  end

  // Screen array; written even when the stream entry is dropped.
  always_ff @(posedge clk) begin
    if (scr_we) scr_mem_q[scr_idx] <= outM;
  end

  // Keyboard register next-state: load on strobe, otherwise hold.
  always_comb begin
    kbd_d = kbd_q;
    if (kbd_valid) kbd_d = kbd_code;
  end

  // Keyboard register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) kbd_q <= '0;
    else        kbd_q <= kbd_d;
  end

  assign fifo_pop = scr_valid && scr_ready;

  // Overflow is sticky: a screen write that finds the FIFO full with no pop is lost.
  always_comb begin
    ovf_d = ovf_q;
    if (scr_we && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign push_entry.addr = addressM[SCR_OFFSET_W-1:0];
  assign push_entry.data = outM;

  screen_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (SCR_ENTRY_W)
  ) u_screen_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (scr_we),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign scr_valid    = !fifo_empty;
  assign scr_addr     = head_entry.addr;
  assign scr_data     = head_entry.data;
  assign scr_overflow = ovf_q;

endmodule

// File: doc/hack_memory.md
# hack_memory

Data-memory responder for the Hack CPU: answers the CPU's `addressM`/`outM`/`writeM` requests and supplies `inM`. It decodes the 16-bit address space into RAM, screen memory and a keyboard register. It also latches keyboard codes from an external source and streams every screen write to a display agent through a small valid/ready FIFO. It sits between the CPU and the top-level I/O, alongside the instruction ROM.

## Interface
Parameters:
- `RAM_WORDS`, 16384, RAM depth in words (addresses 0 .. RAM_WORDS-1).
- `SCREEN_WORDS`, 8192, screen memory depth in words.
- `FIFO_DEPTH`, 4, screen-update FIFO entries; must be a power of two, at least 2.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low.
- `addressM` input 16: CPU data address.
- `outM` input 16: CPU write data.
- `writeM` input 1: CPU write enable.
- `inM` output 16: read data to CPU, combinational from `addressM`.
- `kbd_valid` input 1: one-cycle strobe; `kbd_code` is valid this cycle.
- `kbd_code` input 16: key code; 0 means no key pressed.
- `scr_valid` output 1: FIFO head holds a screen update.
- `scr_ready` input 1: display agent accepts the head entry.
- `scr_addr` output 13: screen word offset of the head entry.
- `scr_data` output 16: pixel word of the head entry.
- `scr_overflow` output 1: sticky flag; a screen update was dropped.

## Operation
Address decode, using `addressM` unsigned:
- 0x0000–0x3FFF: RAM (index `addressM[13:0]`).
- 0x4000–0x5FFF: screen (offset `addressM[12:0]`).
- 0x6000: keyboard register, read-only.
- 0x6001–0xFFFF: unmapped. Reads return 0; writes are ignored.

Reads:
- `inM` is an asynchronous read of the selected region in the same cycle. The CPU is single-cycle and has no wait state.

Writes:
- When `writeM`=1 at the clock edge, the selected RAM or screen word takes the value of `outM`.
- Writes to 0x6000 are ignored.

Keyboard:
- On `kbd_valid`=1, the keyboard register loads `kbd_code`.
- The register holds its value until the next strobe.

Screen stream:
- Every accepted screen write also pushes {`addressM[12:0]`, `outM`} into the FIFO.
- A pop occurs when `scr_valid` and `scr_ready` are both 1.
- Push while full with no pop in the same cycle: the entry is dropped and `scr_overflow` is set. The screen memory is still written.
- Push while full with a simultaneous pop: both happen, and the occupancy stays full.
- Push while empty: the entry becomes visible at the head on the next cycle (no fall-through).
- `scr_addr`/`scr_data` hold stable while `scr_valid`=1 and `scr_ready`=0.

Reset (`reset`=0 at the edge):
- Keyboard register, FIFO pointers and count, and `scr_overflow` are cleared. A reset in mid-stream discards pending entries.
- RAM and screen contents are not cleared.
- Writes and keyboard strobes in the reset cycle are ignored.

## Timing
- Read latency is 0 cycles (combinational).
- Write latency is 1 edge; a read-after-write returns the new value in the cycle after the edge.
- Keyboard latency: strobe at edge N, value readable at 0x6000 after edge N.
- FIFO latency: write at edge N gives `scr_valid`=1 after edge N.
- Output values after reset: `scr_valid`=0, `scr_overflow`=0, `inM` at 0x6000 = 0.
- Sustained throughput is one pop per cycle.

## Structure
- Shared package constants:
  - `SCREEN_BASE` = 16'h4000
  - `KBD_ADDR` = 16'h6000
  - `SCR_OFFSET_W` = 13
  - region-select encoding: RAM, SCREEN, KBD, NONE.
- Sub-module `screen_fifo`: parameterised synchronous FIFO. It has `clk`, `reset`, push/pop, full/empty, and a 29-bit data path.
- The top level holds the decoder, the two memory arrays, the keyboard register and the overflow flag.

## Test plan
- RAM: write 0x1234 to 0x0010, then read 0x0010 → `inM`=0x1234 the next cycle. Read 0x7000 → `inM`=0.
- Keyboard: strobe `kbd_code`=0x0041, read 0x6000 → 0x0041. Write 0xFFFF to 0x6000 → a read still returns 0x0041. Strobe 0 → the read returns 0.
- Screen stream: with `scr_ready`=0, write 0xAAAA to 0x4005 → `scr_valid`=1, `scr_addr`=5, `scr_data`=0xAAAA, held stable. Raise `scr_ready` → one pop, then `scr_valid`=0.
- Overflow: with `scr_ready`=0, make 5 screen writes (values 1–5) → the FIFO holds 1–4 and `scr_overflow`=1. Screen word 5 still reads back 5.
- Full push and pop: with the FIFO full, write and pop in the same cycle → occupancy stays 4, no overflow, and the order is preserved.
- Reset mid-operation: with 3 entries queued and keyboard value 0x0041, pulse `reset`=0 for one cycle → `scr_valid`=0, `scr_overflow`=0, and 0x6000 reads 0. Previously written RAM word 0x0010 still reads 0x1234.
